// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the M-stage data-memory access controller:
// FSM state encoding, load/store width codes and lane-offset helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [2:0] DW_B  = 3'b000;
  localparam logic [2:0] DW_H  = 3'b001;
  localparam logic [2:0] DW_W  = 3'b010;
  localparam logic [2:0] DW_BU = 3'b100;
  localparam logic [2:0] DW_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // Byte offset actually used for lane steering; misaligned low bits are masked.
  function automatic logic [1:0] lane_offset(input logic [2:0] width, input logic [1:0] a);
    case (width)
      DW_B, DW_BU: return a;
      DW_H, DW_HU: return {a[1], 1'b0};
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] a);
    case (width)
      DW_B, DW_BU: return 1'b0;
      DW_H, DW_HU: return a[0];
      default:     return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the read
// word and sign- or zero-extends it according to the load width.
module load_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  width_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*offset_i +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (width_i)
      DW_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      DW_BU:   data_o = {24'h0, byte_sel};
      DW_H:    data_o = {{16{half_sel[15]}}, half_sel};
      DW_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access sequencer over a req/ack port, with pipeline stall,
// store lane formatting and load alignment. Optional: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  DataWidthM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        TimeoutErr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  width_q, width_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        access;
  logic [1:0]  off_new;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_data;

  load_align u_load_align (
    .offset_i (off_q),
    .width_i  (width_q),
    .rdata_i  (mem_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    access  = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    off_new = lane_offset(DataWidthM, ALUOutM[1:0]);
    case (DataWidthM)
      DW_B, DW_BU: begin
        be_new    = 4'b0001 << off_new;
        wdata_new = {4{WriteDataM[7:0]}};
      end
      DW_H, DW_HU: begin
        be_new    = 4'b0011 << off_new;
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'hF;
        wdata_new = WriteDataM;
      end
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    width_d   = width_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    StallM    = 1'b0;
    MisalignM = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access) begin
          StallM  = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUOutM[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          width_d = DataWidthM;
          off_d   = off_new;
          cnt_d   = CW'(1);
          state_d = REQ;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          // Misaligned access is reported and retired without touching memory.
          if (is_misaligned(DataWidthM, ALUOutM[1:0])) begin
            MisalignM = 1'b1;
            be_d      = 4'h0;
            rdata_d   = '0;
            cnt_d     = '0;
            state_d   = DONE;
          end
`endif
        end
      end
      REQ: begin
        StallM = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (mem_ack) begin
          if (!we_q) rdata_d = load_data;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      default: StallM = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      width_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      width_q <= width_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req    = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign ReadDataM  = rdata_q;
  assign TimeoutErr = (state_q == ERR);

endmodule
